// File: rtl/mips_pkg.sv
// Shared EX-stage types for the multiply/divide unit.
// Operation and state encodings plus small op-decode helpers.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_ITER,
        MD_FIX
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multicycle multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide share one adder over WIDTH steps.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    muldiv_op_t      op_e;
    muldiv_state_t   state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*WIDTH:0] acc_q;
    logic [2*WIDTH:0] acc_d;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic            div_q;
    logic            neg_q;
    logic            negr_q;
    logic            dz_q;
    logic            done_q;
    logic            dzo_q;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_w;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic [WIDTH+1:0] add_r;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign op_e = muldiv_op_t'(op);

    always_comb begin
        sgn   = op_is_signed(op_e);
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_abs = a_neg ? -a : a;
        b_abs = b_neg ? -b : b;
    end

    // Divide: add_r[WIDTH+1] is the no-borrow flag of rem - divisor.
    always_comb begin
        rem_w = acc_q[2*WIDTH-1:WIDTH-1];
        add_x = div_q ? rem_w : acc_q[2*WIDTH:WIDTH];
        add_y = div_q ? ~{1'b0, dvs_q}
                      : ({(WIDTH+1){acc_q[0]}} & {1'b0, dvs_q});
        add_r = {1'b0, add_x} + {1'b0, add_y}
              + {{(WIDTH+1){1'b0}}, div_q};
        if (!div_q) begin
            acc_d = {1'b0, add_r[WIDTH:0], acc_q[WIDTH-1:1]};
        end else if (add_r[WIDTH+1]) begin
            acc_d = {1'b0, add_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {rem_w, acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH]
                          : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dzo_q  <= 1'b0;
            if (flush) begin
                state_q <= MD_IDLE;
            end else begin
                unique case (state_q)
                    MD_IDLE: begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                        if (start) begin
                            state_q <= MD_ITER;
                            cnt_q   <= '0;
                            acc_q   <= {{(WIDTH+1){1'b0}}, a_abs};
                            dvs_q   <= b_abs;
                            a_q     <= a;
                            div_q   <= op_is_div(op_e);
                            neg_q   <= a_neg ^ b_neg;
                            negr_q  <= a_neg;
                            dz_q    <= op_is_div(op_e) && (b == '0);
                        end
                    end
                    MD_ITER: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH-1)) state_q <= MD_FIX;
                    end
                    MD_FIX: begin
                        state_q <= MD_IDLE;
                        done_q  <= 1'b1;
                        dzo_q   <= dz_q;
                        // A zero divisor reports the raw dividend, unsigned.
                        if (!div_q) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else if (dz_q) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                    default: state_q <= MD_IDLE;
                endcase
            end
        end
    end

    assign busy     = (state_q != MD_IDLE);
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
